// File: rtl/processor_pkg.sv
// rtl/processor_pkg.sv - shared types and constants for the instruction sequencer
package processor_pkg;

  localparam int DW = 32;

  localparam logic [DW-1:0] NOP_INSTR = '0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - load, run-control, issue and result-capture signals of the sequencer
interface instr_sequencer_if #(
  parameter int DEPTH = 16,
  parameter int DW    = processor_pkg::DW
) ();

  localparam int AW = $clog2(DEPTH);

  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic          start;
  logic [AW:0]   prog_len;
  logic          hold;
  logic [DW-1:0] instruction;
  logic [DW-1:0] result;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic [AW-1:0] res_index;
  logic          busy;
  logic          done;

  // master is the sequencer; slave is the host plus the processor it feeds
  modport master (
    input  load_en, load_addr, load_data, start, prog_len, hold, result,
    output instruction, res_valid, res_data, res_index, busy, done
  );

  modport slave (
    output load_en, load_addr, load_data, start, prog_len, hold, result,
    input  instruction, res_valid, res_data, res_index, busy, done
  );

endinterface

// File: rtl/prog_mem.sv
// rtl/prog_mem.sv - program memory, synchronous write, asynchronous read, no reset
module prog_mem #(
  parameter  int DEPTH = 16,
  parameter  int DW    = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - issues a loaded program one instruction per unheld cycle and captures results
module instr_sequencer #(
  parameter int DEPTH = 16,
  parameter int DW    = processor_pkg::DW
) (
  input  logic              clk,
  input  logic              reset,
  instr_sequencer_if.master bus
);

  import processor_pkg::*;

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

  state_t        state, state_nxt;
  logic [AW-1:0] pc, pc_nxt;
  logic [AW:0]   len, len_nxt;
  logic [DW-1:0] instr_q, instr_nxt;
  logic [DW-1:0] res_data_q, res_data_nxt;
  logic [AW-1:0] res_index_q, res_index_nxt;
  logic          res_valid_q, res_valid_nxt;
  logic          done_q, done_nxt;

  logic          mem_wr;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] fetch_data;
  logic          last;

  assign mem_wr = bus.load_en && (state == IDLE);

  prog_mem #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_prog_mem (
    .clk     (clk),
    .wr_en   (mem_wr),
    .wr_addr (bus.load_addr),
    .wr_data (bus.load_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // A word written in the start cycle must be the one issued, so bypass the array
  assign fetch_data = (mem_wr && (bus.load_addr == rd_addr)) ? bus.load_data : rd_data;
  assign last       = (({1'b0, pc}) + (AW+1)'(1)) == len;

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    len_nxt       = len;
    instr_nxt     = instr_q;
    res_data_nxt  = res_data_q;
    res_index_nxt = res_index_q;
    res_valid_nxt = 1'b0;
    done_nxt      = 1'b0;
    rd_addr       = '0;

    case (state)
      IDLE: begin
        instr_nxt = DW'(NOP_INSTR);
        if (bus.start) begin
          if (bus.prog_len == '0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = RUN;
            pc_nxt    = '0;
            len_nxt   = (bus.prog_len > LEN_MAX) ? LEN_MAX : bus.prog_len;
            instr_nxt = fetch_data;
          end
        end
      end

      RUN: begin
        rd_addr = pc + AW'(1);
        if (!bus.hold) begin
          res_data_nxt  = bus.result;
          res_index_nxt = pc;
          res_valid_nxt = 1'b1;
          if (last) begin
            state_nxt = IDLE;
            pc_nxt    = '0;
            instr_nxt = DW'(NOP_INSTR);
            done_nxt  = 1'b1;
          end else begin
            pc_nxt    = pc + AW'(1);
            instr_nxt = fetch_data;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      len         <= '0;
      instr_q     <= '0;
      res_data_q  <= '0;
      res_index_q <= '0;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      len         <= len_nxt;
      instr_q     <= instr_nxt;
      res_data_q  <= res_data_nxt;
      res_index_q <= res_index_nxt;
      res_valid_q <= res_valid_nxt;
      done_q      <= done_nxt;
    end
  end

  assign bus.instruction = instr_q;
  assign bus.res_data    = res_data_q;
  assign bus.res_index   = res_index_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.done        = done_q;
  assign bus.busy        = (state == RUN);

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL take parameter DEPTH, default 16, the number of program-memory words (power of two, at least 2).
REQ-002 The block SHALL take parameter DW, default 32, the instruction and result width.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset, with ports as follows.
- clk  in  1  system clock, rising-edge active.
- reset  in  1  asynchronous, active-high reset.
- load_en  in  1  program-word write strobe.
- load_addr  in  log2(DEPTH)  program-word write address.
- load_data  in  DW  program word to write.
- start  in  1  single-cycle run request.
- prog_len  in  log2(DEPTH)+1  number of instructions to issue.
- hold  in  1  pause issue while high.
- instruction  out  DW  instruction presented to the processor.
- result  in  DW  processor result for the current instruction; combinational in that instruction.
- res_valid  out  1  single-cycle result-capture strobe.
- res_data  out  DW  captured result.
- res_index  out  log2(DEPTH)  program index of the captured result.
- busy  out  1  run in progress.
- done  out  1  single-cycle run-complete strobe.

Function
REQ-004 Program memory SHALL be written at a rising edge when load_en=1 and busy=0; load_en while busy=1 SHALL be ignored.
REQ-005 The state machine SHALL have states IDLE and RUN; busy SHALL equal (state==RUN).
REQ-006 In IDLE, start=1 with prog_len>=1 SHALL, at the next edge, do the following.
- Enter RUN.
- Set pc=0.
- Load instruction <= mem[0].
- Latch len = min(prog_len, DEPTH).
REQ-007 In IDLE, start=1 with prog_len=0 SHALL pulse done at the next edge, stay in IDLE and issue nothing.
REQ-008 start while in RUN SHALL be ignored.
REQ-009 In RUN with hold=0, each edge SHALL do the following.
- Capture res_data <= result.
- Set res_index <= pc.
- Pulse res_valid=1 for one cycle.
REQ-010 At that same edge, when pc < len-1, the block SHALL set pc <= pc+1 and instruction <= mem[pc+1].
REQ-011 At that same edge, when pc == len-1, the block SHALL perform all of the following.
- Set instruction <= NOP (all zeros).
- Pulse done for one cycle, coincident with the final res_valid.
- Return to IDLE.
REQ-012 In RUN with hold=1, instruction, pc, res_data and res_index SHALL hold, and res_valid SHALL be 0.
REQ-013 Latency SHALL be as follows.
- Each instruction is presented for at least one full cycle.
- Its result is captured at the edge ending that cycle.
- res_valid is visible in the following cycle.
- An unheld run of N instructions takes N cycles from the first instruction to done.
REQ-014 instruction SHALL be NOP whenever the state is IDLE.
REQ-015 When load_en and start occur in the same cycle in IDLE, the write SHALL complete first; if load_addr=0, the run SHALL issue the new word.
REQ-016 pc SHALL never exceed len-1, so it never wraps past DEPTH-1.
REQ-017 res_data and res_index SHALL keep their last captured values while in IDLE.

Reset
REQ-018 Asserting reset SHALL immediately set the following, including during a run.
- state=IDLE, pc=0.
- instruction=0, res_data=0, res_index=0.
- res_valid=0, busy=0, done=0.
REQ-019 reset SHALL NOT clear program memory; its contents are undefined until written.
REQ-020 A run aborted by reset SHALL NOT produce a done pulse.

Structure
REQ-021 The shared package processor_pkg SHALL hold DW, the NOP_INSTR constant (all zeros) and the IDLE/RUN state enum.
REQ-022 Program memory SHALL be a sub-module prog_mem with synchronous write, asynchronous read and no reset.

Verification
REQ-023 The bench SHALL model the processor as result = instruction + 1 and cover the following scenarios.
- Load mem[0..2] = 0x10, 0x20, 0x30; start with prog_len=3.
  - res_valid for 3 consecutive cycles.
  - res_data = 0x11, 0x21, 0x31 with res_index = 0, 1, 2.
  - done on the third strobe; instruction=0 afterwards.
- Same program with hold=1 for 2 cycles after the first capture.
  - instruction stays 0x20 and no res_valid during the hold.
  - Then 0x21 and 0x31 are captured.
- prog_len=0 -> done one cycle after start, no res_valid, busy stays 0.
- prog_len=20 with DEPTH=16 -> exactly 16 res_valid pulses (indices 0..15), then done.
- Assert reset mid-run at index 1 -> all outputs 0 at once; no done; a subsequent run reproduces the values stored before the reset.
- Pulse load_en (addr 0, data 0x99) while busy -> ignored; the next run captures 0x11 at index 0.
